// File: rtl/barcode_mimic_gen_pkg.sv
// barcode_mimic_gen_pkg: shared types, widths and low-time helper for the barcode stimulus source
package barcode_pkg;
  typedef enum logic [1:0] {IDLE, START, LOW, HIGH} bc_state_t;
  localparam int BC_BITS = 8;
  localparam int BC_PERIOD_W = 22;
  localparam int BC_MIN_PERIOD = 8;
  // '1' is a short (quarter) low pulse, '0' the complementary long one
  function automatic logic [BC_PERIOD_W-1:0] low_time(input logic [BC_PERIOD_W-1:0] p, input logic b);
    return b ? p >> 2 : p - (p >> 2);
  endfunction
endpackage

// File: rtl/barcode_mimic_gen_bit_timer.sv
// bc_bit_timer: loadable down-counter with zero flag, times each low and high segment
module bc_bit_timer
  import barcode_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load,
  input  logic [BC_PERIOD_W-1:0] load_val,
  output logic                   zero
);
  logic [BC_PERIOD_W-1:0] cnt;
  always_ff @(posedge clk)
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (cnt != '0) cnt <= cnt - BC_PERIOD_W'(1);
  assign zero = cnt == '0;
endmodule

// File: rtl/barcode_mimic_gen.sv
// barcode_mimic_gen: serialises station_ID onto BC with pulse-width coding, MSB first.
// BARCODE_MIMIC_START_BIT_EN adds a leading half-period calibration bit.
module barcode_mimic_gen
  import barcode_pkg::*;
#(
  parameter int MIN_PERIOD = BC_MIN_PERIOD
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [BC_PERIOD_W-1:0] period,
  input  logic                   send,
  input  logic [BC_BITS-1:0]     station_ID,
  output logic                   BC_done,
  output logic                   BC
);
  bc_state_t state;
  logic [BC_BITS-1:0] sr;
  logic [2:0] bit_cnt;
  logic [BC_PERIOD_W-1:0] p, pc, ld_val;
  logic ld, zero;
`ifdef BARCODE_MIMIC_START_BIT_EN
  logic cal;
`endif
  assign pc = period < BC_PERIOD_W'(MIN_PERIOD) ? BC_PERIOD_W'(MIN_PERIOD) : period;
  // timer loads n-1 so a segment of n clocks ends when the counter reads zero
  always_comb begin
    ld = 1'b0;
    ld_val = '0;
    case (state)
      IDLE: begin
        ld = send;
`ifdef BARCODE_MIMIC_START_BIT_EN
        ld_val = (pc >> 1) - BC_PERIOD_W'(1);
`else
        ld_val = low_time(pc, station_ID[BC_BITS-1]) - BC_PERIOD_W'(1);
`endif
      end
`ifdef BARCODE_MIMIC_START_BIT_EN
      START: begin
        ld = zero;
        ld_val = p - (p >> 1) - BC_PERIOD_W'(1);
      end
`endif
      LOW: begin
        ld = zero;
        ld_val = p - low_time(p, sr[BC_BITS-1]) - BC_PERIOD_W'(1);
      end
      HIGH: begin
        ld = zero && bit_cnt != 3'(BC_BITS-1);
        ld_val = low_time(p, sr[BC_BITS-2]) - BC_PERIOD_W'(1);
`ifdef BARCODE_MIMIC_START_BIT_EN
        if (cal) begin
          ld = zero;
          ld_val = low_time(p, sr[BC_BITS-1]) - BC_PERIOD_W'(1);
        end
`endif
      end
      default: ;
    endcase
  end
  bc_bit_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (ld),
    .load_val (ld_val),
    .zero     (zero)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      sr <= '0;
      bit_cnt <= '0;
      p <= '0;
      BC <= 1'b1;
      BC_done <= 1'b0;
`ifdef BARCODE_MIMIC_START_BIT_EN
      cal <= 1'b0;
`endif
    end else begin
      BC_done <= 1'b0;
      case (state)
        IDLE: if (send) begin
          sr <= station_ID;
          p <= pc;
          bit_cnt <= '0;
          BC <= 1'b0;
`ifdef BARCODE_MIMIC_START_BIT_EN
          state <= START;
`else
          state <= LOW;
`endif
        end
`ifdef BARCODE_MIMIC_START_BIT_EN
        START: if (zero) begin
          BC <= 1'b1;
          cal <= 1'b1;
          state <= HIGH;
        end
`endif
        LOW: if (zero) begin
          BC <= 1'b1;
          state <= HIGH;
        end
        HIGH: if (zero) begin
`ifdef BARCODE_MIMIC_START_BIT_EN
          if (cal) begin
            cal <= 1'b0;
            BC <= 1'b0;
            state <= LOW;
          end else
`endif
          if (bit_cnt == 3'(BC_BITS-1)) begin
            bit_cnt <= bit_cnt + 3'd1;
            BC_done <= 1'b1;
            state <= IDLE;
          end else begin
            sr <= sr << 1;
            bit_cnt <= bit_cnt + 3'd1;
            BC <= 1'b0;
            state <= LOW;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_barcode_mimic_gen.sv
// tb_barcode_mimic_gen: table-driven, random and hand-written checks of the barcode waveform
module tb_barcode_mimic_gen;
`ifdef BARCODE_MIMIC_START_BIT_EN
  localparam int NB = 9, OFS = 1;
`else
  localparam int NB = 8, OFS = 0;
`endif
  logic clk = 0, rst_n = 0, send = 0, BC_done, BC;
  logic [21:0] period = '0;
  logic [7:0] station_ID = '0;
  int checks = 0, errors = 0;

  barcode_mimic_gen dut (
    .clk(clk), .rst_n(rst_n), .period(period), .send(send),
    .station_ID(station_ID), .BC_done(BC_done), .BC(BC)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  id;
    logic [21:0] per;
    int lo1, lo0, pe, inj;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // called at a negedge; returns at the negedge where BC_done is seen
  task automatic run_frame(input vec_t v);
    logic w[$];
    int st[$];
    int done_at = -1, j, hi;
    station_ID = v.id;
    period = v.per;
    send = 1;
    @(negedge clk);
    send = 0;
    check("latency_bc", int'(BC), 0);
    check("first_done", int'(BC_done), 0);
    for (int i = 0; i < NB * v.pe + 20; i++) begin
      w.push_back(BC);
      if (BC_done) begin
        done_at = i;
        break;
      end
      if (i == v.inj) begin
        send = 1;
        station_ID = 8'hFF;
        period = 22'd5;
      end else if (i == v.inj + 1) send = 0;
      @(negedge clk);
    end
    send = 0;
    check("done_at", done_at, NB * v.pe);
    if (done_at < 0) return;
    check("done_bc", int'(BC), 1);
    st.push_back(0);
    for (int i = 1; i < w.size(); i++)
      if (w[i-1] && !w[i]) st.push_back(i);
    check("bit_count", st.size(), NB);
    for (int k = 0; k < st.size() && k < NB; k++) begin
      j = st[k];
      while (j < w.size() && !w[j]) j++;
      hi = (k + 1 < st.size()) ? st[k+1] : done_at;
      if (OFS == 1 && k == 0) check("start_low", j - st[k], v.pe / 2);
      else check($sformatf("low_bit%0d", 7 - (k - OFS)), j - st[k],
                 v.id[7 - (k - OFS)] ? v.lo1 : v.lo0);
      check($sformatf("period_seg%0d", k), hi - st[k], v.pe);
    end
  endtask

  vec_t tbl[8];
  vec_t r;
  int bad, pe;

  initial begin
    tbl[0] = '{8'h01, 22'h1000, 1024, 3072, 4096, -1};
    tbl[1] = '{8'hA5, 22'd100, 25, 75, 100, -1};
    tbl[2] = '{8'h3C, 22'd3, 2, 6, 8, -1};
    tbl[3] = '{8'h96, 22'd100, 25, 75, 100, 250};
    tbl[4] = '{8'h00, 22'd9, 2, 7, 9, -1};
    tbl[5] = '{8'hFF, 22'd0, 2, 6, 8, -1};
    tbl[6] = '{8'h5A, 22'd13, 3, 10, 13, 40};
    tbl[7] = '{8'hC3, 22'd64, 16, 48, 64, -1};
    repeat (2) begin
      @(negedge clk);
      check("rst_bc", int'(BC), 1);
      check("rst_done", int'(BC_done), 0);
    end
    rst_n = 1;
    repeat (3) begin
      @(negedge clk);
      check("idle_bc", int'(BC), 1);
      check("idle_done", int'(BC_done), 0);
    end
    foreach (tbl[i]) begin
      run_frame(tbl[i]);
      repeat (i % 3) @(negedge clk);
    end
    // back-to-back: next send lands in the BC_done cycle
    run_frame(tbl[1]);
    run_frame(tbl[6]);
    for (int n = 0; n < 25; n++) begin
      r.id = 8'($urandom);
      r.per = 22'($urandom_range(0, 60));
      pe = (r.per < 8) ? 8 : int'(r.per);
      r.pe = pe;
      r.lo1 = pe / 4;
      r.lo0 = pe - pe / 4;
      r.inj = $urandom_range(0, 1) ? int'($urandom_range(1, NB * pe - 3)) : -1;
      run_frame(r);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    @(negedge clk);
    check("post_idle_done", int'(BC_done), 0);
    // reset during bit 4 aborts the frame with no BC_done
    station_ID = 8'h00;
    period = 22'd20;
    send = 1;
    @(negedge clk);
    send = 0;
    repeat (4 * 20 + 3) @(negedge clk);
    check("bit4_low", int'(BC), 0);
    rst_n = 0;
    @(negedge clk);
    check("abort_bc", int'(BC), 1);
    check("abort_done", int'(BC_done), 0);
    @(negedge clk);
    rst_n = 1;
    bad = 0;
    repeat (200) begin
      @(negedge clk);
      if (BC_done || !BC) bad++;
    end
    check("abort_quiet", bad, 0);
    r = '{8'h81, 22'd3, 2, 6, 8, -1};
    run_frame(r);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
